ddr_rd_arbiter: RTL and testbench

Shares the single DDR read-burst port between two requesters: the instruction-cache ISA loader and the AP data loader.
- Grants one complete burst at a time.
- Forwards address and length to the DDR interface.
- Returns a per-requester beat count, valid and data, so each requester sees a private DDR read port.
- Sits between ins_cache / data loader and the DDR interface.

---
 rtl/ddr_rd_arbiter.sv | 150 +++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// rtl/ddr_rd_arbiter.sv - shares one DDR read-burst port between ISA and data loaders
// Optional build macro RR_ARB_EN: round-robin arbitration instead of fixed ISA priority.
module ddr_rd_arbiter #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30,
  parameter int DATA_WIDTH     = 16,
  parameter int LEN_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      isa_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] isa_rd_addr,
  input  logic [LEN_WIDTH-1:0]      isa_rd_len,
  output logic                      isa_rd_grant,
  output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
  output logic                      isa_rd_data_valid,
  output logic [ISA_WIDTH-1:0]      isa_rd_data,
  input  logic                      dat_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] dat_rd_addr,
  input  logic [LEN_WIDTH-1:0]      dat_rd_len,
  output logic                      dat_rd_grant,
  output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
  output logic                      dat_rd_data_valid,
  output logic [DATA_WIDTH-1:0]     dat_rd_data,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [LEN_WIDTH-1:0]      rd_burst_len,
  input  logic                      rd_burst_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  input  logic                      rd_burst_finish
);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, HOLD = 2'd2, GAP = 2'd3} state_t;

  state_t               state, state_nxt;
  logic                 pick_isa, pick_dat, any_pick, owner_req, beat;
  logic [LEN_WIDTH-1:0] pick_len;
  logic                 unused_hi;

`ifdef RR_ARB_EN
  // 1 when the data loader was the most recent grant
  logic last_dat;
`endif

  // Upper DDR data bits feed neither requester.
  assign unused_hi = ^rd_burst_data[DDR_DATA_WIDTH-1:ISA_WIDTH];

  // Choose a winner among the current requests.
  always_comb begin
    pick_isa = 1'b0;
    pick_dat = 1'b0;
`ifdef RR_ARB_EN
    if (isa_rd_req && dat_rd_req) begin
      pick_isa = last_dat;
      pick_dat = !last_dat;
    end else begin
      pick_isa = isa_rd_req;
      pick_dat = dat_rd_req;
    end
`else
    pick_isa = isa_rd_req;
    pick_dat = !isa_rd_req && dat_rd_req;
`endif
  end

  assign any_pick  = pick_isa || pick_dat;
  assign pick_len  = pick_isa ? isa_rd_len : dat_rd_len;
  assign owner_req = (isa_rd_grant && isa_rd_req) || (dat_rd_grant && dat_rd_req);
  assign beat      = (state == BURST) && rd_burst_data_valid;

  // Beat strobes pass straight through to whoever owns the port.
  assign isa_rd_data_valid = beat && isa_rd_grant;
  assign dat_rd_data_valid = beat && dat_rd_grant;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a zero-length grant skips the DDR access entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pick) state_nxt = (pick_len == '0) ? HOLD : BURST;
      BURST:   if (rd_burst_finish) state_nxt = HOLD;
      HOLD:    if (!owner_req) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, snapshot, DDR request, and per-requester beat capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isa_rd_grant  <= 1'b0;
      dat_rd_grant  <= 1'b0;
      isa_rd_cnt    <= '0;
      dat_rd_cnt    <= '0;
      isa_rd_data   <= '0;
      dat_rd_data   <= '0;
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
`ifdef RR_ARB_EN
      last_dat      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_pick) begin
            isa_rd_grant  <= pick_isa;
            dat_rd_grant  <= pick_dat;
            rd_burst_addr <= pick_isa ? isa_rd_addr : dat_rd_addr;
            rd_burst_len  <= pick_len;
            rd_burst_req  <= (pick_len != '0);
            if (pick_isa) isa_rd_cnt <= '0;
            if (pick_dat) dat_rd_cnt <= '0;
`ifdef RR_ARB_EN
            last_dat      <= pick_dat;
`endif
          end
        end
        BURST: begin
          if (isa_rd_data_valid) begin
            isa_rd_data <= rd_burst_data[ISA_WIDTH-1:0];
            if (isa_rd_cnt != '1) isa_rd_cnt <= isa_rd_cnt + LEN_WIDTH'(1);
          end
          if (dat_rd_data_valid) begin
            dat_rd_data <= rd_burst_data[DATA_WIDTH-1:0];
            if (dat_rd_cnt != '1) dat_rd_cnt <= dat_rd_cnt + LEN_WIDTH'(1);
          end
          if (rd_burst_finish) rd_burst_req <= 1'b0;
        end
        HOLD: begin
          // Release only once the owner has seen its count and dropped req.
          if (!owner_req) begin
            isa_rd_grant <= 1'b0;
            dat_rd_grant <= 1'b0;
            isa_rd_cnt   <= '0;
            dat_rd_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb/tb_ddr_rd_arbiter.sv - self-checking bench for ddr_rd_arbiter
module tb_ddr_rd_arbiter;
  localparam int AW = 28, DW = 64, IW = 30, TW = 16, LW = 10;

  logic          clk, rst;
  logic          isa_rd_req, dat_rd_req;
  logic [AW-1:0] isa_rd_addr, dat_rd_addr;
  logic [LW-1:0] isa_rd_len, dat_rd_len;
  logic          isa_rd_grant, dat_rd_grant;
  logic [LW-1:0] isa_rd_cnt, dat_rd_cnt;
  logic          isa_rd_data_valid, dat_rd_data_valid;
  logic [IW-1:0] isa_rd_data;
  logic [TW-1:0] dat_rd_data;
  logic          rd_burst_req;
  logic [AW-1:0] rd_burst_addr;
  logic [LW-1:0] rd_burst_len;
  logic          rd_burst_data_valid;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_finish;

  int n_checks = 0;
  int n_fail   = 0;
  int isa_strobes = 0;
  int dat_strobes = 0;
  logic [IW-1:0] exp_isa_data = '0;
  logic [TW-1:0] exp_dat_data = '0;
`ifdef RR_ARB_EN
  bit model_last_isa = 1'b0;
`endif

  ddr_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .isa_rd_req(isa_rd_req), .isa_rd_addr(isa_rd_addr), .isa_rd_len(isa_rd_len),
    .isa_rd_grant(isa_rd_grant), .isa_rd_cnt(isa_rd_cnt),
    .isa_rd_data_valid(isa_rd_data_valid), .isa_rd_data(isa_rd_data),
    .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_len(dat_rd_len),
    .dat_rd_grant(dat_rd_grant), .dat_rd_cnt(dat_rd_cnt),
    .dat_rd_data_valid(dat_rd_data_valid), .dat_rd_data(dat_rd_data),
    .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle
  always @(negedge clk) begin
    if (isa_rd_data_valid) isa_strobes++;
    if (dat_rd_data_valid) dat_strobes++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: ISA wins ties, or the requester not served last when round-robin.
  task automatic model_pick(input bit i, input bit d, output bit win_isa);
    win_isa = i;
`ifdef RR_ARB_EN
    if (i && d) win_isa = !model_last_isa;
    model_last_isa = win_isa;
`endif
    if (!i && !d) win_isa = 1'b0;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (!(isa_rd_grant || dat_rd_grant) && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic send_beats(input int n, input bit gaps, output logic [DW-1:0] last);
    last = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      rd_burst_data_valid = 1'b1;
      rd_burst_data = {$urandom(), $urandom()};
      last = rd_burst_data;
      tick();
      rd_burst_data_valid = 1'b0;
    end
  endtask

  task automatic finish_burst();
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    isa_rd_req = 0; dat_rd_req = 0; isa_rd_addr = '0; dat_rd_addr = '0;
    isa_rd_len = '0; dat_rd_len = '0;
    rd_burst_data_valid = 0; rd_burst_data = '0; rd_burst_finish = 0;
    tick(); tick();
    n_checks++;
    if ({isa_rd_grant, dat_rd_grant, rd_burst_req, isa_rd_cnt, dat_rd_cnt, isa_rd_data, dat_rd_data,
         rd_burst_addr, rd_burst_len, isa_rd_data_valid, dat_rd_data_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grants %b%b req %b cnts %0d/%0d addr %h len %0d want all 0",
               isa_rd_grant, dat_rd_grant, rd_burst_req, isa_rd_cnt, dat_rd_cnt, rd_burst_addr, rd_burst_len);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_isa_burst();
    logic [DW-1:0] last;
    int cyc, s0, d0;
    bit w;
    model_pick(1, 0, w);
    isa_rd_req = 1; isa_rd_addr = AW'(32'h400); isa_rd_len = LW'(128);
    wait_grant(cyc);
    n_checks++;
    if ({isa_rd_grant, dat_rd_grant, rd_burst_req} !== 3'b101 || cyc != 1) begin
      n_fail++; $display("FAIL isa_grant: got g%b%b req%b after %0d want g10 req1 after 1",
                         isa_rd_grant, dat_rd_grant, rd_burst_req, cyc);
    end
    n_checks++;
    if (rd_burst_addr !== AW'(32'h400) || rd_burst_len !== LW'(128) || isa_rd_cnt !== '0) begin
      n_fail++; $display("FAIL isa_snapshot: got addr %h len %0d cnt %0d want 400 128 0",
                         rd_burst_addr, rd_burst_len, isa_rd_cnt);
    end
    isa_rd_addr = AW'(32'h0abcdef); isa_rd_len = LW'(7);
    s0 = isa_strobes; d0 = dat_strobes;
    send_beats(128, 1, last);
    exp_isa_data = last[IW-1:0];
    n_checks++;
    if (isa_rd_cnt !== LW'(128) || isa_rd_data !== exp_isa_data) begin
      n_fail++; $display("FAIL isa_beats: got cnt %0d data %h want 128 %h", isa_rd_cnt, isa_rd_data, exp_isa_data);
    end
    n_checks++;
    if (isa_strobes - s0 != 128 || dat_strobes != d0 || dat_rd_cnt !== '0 || dat_rd_data !== '0) begin
      n_fail++; $display("FAIL isa_strobes: got isa %0d dat %0d dcnt %0d ddata %h want 128 0 0 0",
                         isa_strobes - s0, dat_strobes - d0, dat_rd_cnt, dat_rd_data);
    end
    n_checks++;
    if (rd_burst_addr !== AW'(32'h400) || rd_burst_len !== LW'(128)) begin
      n_fail++; $display("FAIL isa_snapshot_hold: got addr %h len %0d want 400 128", rd_burst_addr, rd_burst_len);
    end
    finish_burst();
    rd_burst_data_valid = 1; rd_burst_data = {$urandom(), $urandom()};
    tick();
    rd_burst_data_valid = 0;
    n_checks++;
    if ({isa_rd_grant, rd_burst_req} !== 2'b10 || isa_rd_cnt !== LW'(128) ||
        isa_rd_data !== exp_isa_data || isa_strobes - s0 != 128) begin
      n_fail++; $display("FAIL isa_hold: got g%b req%b cnt %0d strobes %0d want g1 req0 cnt 128 strobes 128",
                         isa_rd_grant, rd_burst_req, isa_rd_cnt, isa_strobes - s0);
    end
    isa_rd_req = 0;
    tick();
    n_checks++;
    if (isa_rd_grant !== 1'b0 || isa_rd_cnt !== '0) begin
      n_fail++; $display("FAIL isa_release: got g%b cnt %0d want 0 0", isa_rd_grant, isa_rd_cnt);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] last;
    int cyc;
    bit wi;
    model_pick(1, 1, wi);
    isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = LW'(3);
    dat_rd_req = 1; dat_rd_addr = AW'($urandom()); dat_rd_len = LW'(2);
    wait_grant(cyc);
    n_checks++;
    if ({isa_rd_grant, dat_rd_grant} !== {wi, !wi} ||
        rd_burst_addr !== (wi ? isa_rd_addr : dat_rd_addr)) begin
      n_fail++; $display("FAIL tie_winner: got g%b%b addr %h want g%b%b", isa_rd_grant, dat_rd_grant,
                         rd_burst_addr, wi, !wi);
    end
    send_beats(wi ? 3 : 2, 0, last);
    if (wi) exp_isa_data = last[IW-1:0]; else exp_dat_data = last[TW-1:0];
    finish_burst();
    if (wi) isa_rd_req = 0; else dat_rd_req = 0;
    tick();
    n_checks++;
    if ({isa_rd_grant, dat_rd_grant} !== 2'b00) begin
      n_fail++; $display("FAIL tie_release: got g%b%b want 00", isa_rd_grant, dat_rd_grant);
    end
    tick();
    n_checks++;
    if ({isa_rd_grant, dat_rd_grant} !== 2'b00) begin
      n_fail++; $display("FAIL tie_gap: got g%b%b want 00 during gap", isa_rd_grant, dat_rd_grant);
    end
    model_pick(!wi, wi, wi);
    tick();
    n_checks++;
    if ({isa_rd_grant, dat_rd_grant} !== {wi, !wi} || rd_burst_len !== (wi ? LW'(3) : LW'(2))) begin
      n_fail++; $display("FAIL tie_loser: got g%b%b len %0d want g%b%b", isa_rd_grant, dat_rd_grant,
                         rd_burst_len, wi, !wi);
    end
    send_beats(wi ? 3 : 2, 0, last);
    if (wi) exp_isa_data = last[IW-1:0]; else exp_dat_data = last[TW-1:0];
    finish_burst();
    n_checks++;
    if ((wi ? isa_rd_cnt : dat_rd_cnt) !== (wi ? LW'(3) : LW'(2)) ||
        isa_rd_data !== exp_isa_data || dat_rd_data !== exp_dat_data) begin
      n_fail++; $display("FAIL tie_loser_data: got cnt %0d/%0d data %h/%h want data %h/%h", isa_rd_cnt,
                         dat_rd_cnt, isa_rd_data, dat_rd_data, exp_isa_data, exp_dat_data);
    end
    isa_rd_req = 0; dat_rd_req = 0;
    tick(); tick();
  endtask

  task automatic test_drop_mid_burst();
    logic [DW-1:0] last;
    int cyc;
    bit w;
    model_pick(0, 1, w);
    dat_rd_req = 1; dat_rd_addr = AW'($urandom()); dat_rd_len = LW'(4);
    wait_grant(cyc);
    send_beats(2, 0, last);
    dat_rd_req = 0;
    send_beats(2, 1, last);
    exp_dat_data = last[TW-1:0];
    n_checks++;
    if (rd_burst_req !== 1'b1 || dat_rd_grant !== 1'b1) begin
      n_fail++; $display("FAIL drop_burst_runs: got req%b g%b want 1 1", rd_burst_req, dat_rd_grant);
    end
    finish_burst();
    n_checks++;
    if (dat_rd_grant !== 1'b1 || dat_rd_cnt !== LW'(4) || dat_rd_data !== exp_dat_data) begin
      n_fail++; $display("FAIL drop_hold: got g%b cnt %0d data %h want 1 4 %h", dat_rd_grant, dat_rd_cnt,
                         dat_rd_data, exp_dat_data);
    end
    tick();
    n_checks++;
    if (dat_rd_grant !== 1'b0) begin
      n_fail++; $display("FAIL drop_release: got g%b want 0", dat_rd_grant);
    end
    model_pick(1, 0, w);
    isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = LW'(1);
    wait_grant(cyc);
    n_checks++;
    if (cyc != 2 || isa_rd_grant !== 1'b1) begin
      n_fail++; $display("FAIL drop_next_grant: got g%b after %0d want 1 after 2", isa_rd_grant, cyc);
    end
    send_beats(1, 0, last);
    exp_isa_data = last[IW-1:0];
    finish_burst();
    isa_rd_req = 0;
    tick(); tick();
  endtask

  task automatic test_len_zero();
    int cyc, s0;
    bit w;
    model_pick(1, 0, w);
    isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = '0;
    wait_grant(cyc);
    s0 = isa_strobes;
    for (int i = 0; i < 3; i++) begin
      rd_burst_data_valid = 1; rd_burst_data = {$urandom(), $urandom()};
      tick();
    end
    rd_burst_data_valid = 0;
    n_checks++;
    if ({isa_rd_grant, rd_burst_req} !== 2'b10 || isa_rd_cnt !== '0 || isa_strobes != s0 ||
        isa_rd_data !== exp_isa_data) begin
      n_fail++; $display("FAIL len0_hold: got g%b req%b cnt %0d strobes %0d want g1 req0 cnt0 strobes0",
                         isa_rd_grant, rd_burst_req, isa_rd_cnt, isa_strobes - s0);
    end
    isa_rd_req = 0;
    tick();
    n_checks++;
    if (isa_rd_grant !== 1'b0) begin
      n_fail++; $display("FAIL len0_release: got g%b want 0", isa_rd_grant);
    end
    tick();
  endtask

  task automatic test_idle_pulses();
    int cyc, s0, d0;
    bit w;
    s0 = isa_strobes; d0 = dat_strobes;
    for (int i = 0; i < 6; i++) begin
      rd_burst_data_valid = $urandom_range(0, 1);
      rd_burst_finish = $urandom_range(0, 1);
      rd_burst_data = {$urandom(), $urandom()};
      tick();
    end
    rd_burst_data_valid = 0; rd_burst_finish = 0;
    n_checks++;
    if (isa_strobes != s0 || dat_strobes != d0 || {isa_rd_grant, dat_rd_grant, rd_burst_req} !== 3'b000 ||
        isa_rd_cnt !== '0 || dat_rd_cnt !== '0 || isa_rd_data !== exp_isa_data || dat_rd_data !== exp_dat_data) begin
      n_fail++; $display("FAIL idle_pulses: got strobes %0d/%0d cnt %0d/%0d want 0 0 0 0",
                         isa_strobes - s0, dat_strobes - d0, isa_rd_cnt, dat_rd_cnt);
    end
    model_pick(0, 1, w);
    dat_rd_req = 1; dat_rd_addr = AW'($urandom()); dat_rd_len = LW'(2);
    wait_grant(cyc);
    n_checks++;
    if (cyc != 1 || dat_rd_grant !== 1'b1 || rd_burst_req !== 1'b1) begin
      n_fail++; $display("FAIL idle_still_idle: got g%b req%b after %0d want 1 1 after 1",
                         dat_rd_grant, rd_burst_req, cyc);
    end
    finish_burst();
    n_checks++;
    if (dat_rd_cnt !== '0 || rd_burst_req !== 1'b0) begin
      n_fail++; $display("FAIL empty_finish: got cnt %0d req%b want 0 0", dat_rd_cnt, rd_burst_req);
    end
    dat_rd_req = 0;
    tick(); tick();
  endtask

  task automatic test_saturate();
    logic [DW-1:0] last;
    int cyc, s0;
    bit w;
    model_pick(1, 0, w);
    isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = LW'(1023);
    wait_grant(cyc);
    s0 = isa_strobes;
    send_beats(1025, 0, last);
    exp_isa_data = last[IW-1:0];
    n_checks++;
    if (isa_rd_cnt !== LW'(1023) || isa_strobes - s0 != 1025 || isa_rd_data !== exp_isa_data) begin
      n_fail++; $display("FAIL saturate: got cnt %0d strobes %0d want 1023 1025", isa_rd_cnt, isa_strobes - s0);
    end
    finish_burst();
    isa_rd_req = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] last;
    int cyc;
    bit w;
    model_pick(1, 0, w);
    isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = LW'(16);
    wait_grant(cyc);
    send_beats(4, 0, last);
    rd_burst_data_valid = 1; rd_burst_data = {$urandom(), $urandom()};
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({isa_rd_grant, dat_rd_grant, rd_burst_req, isa_rd_cnt, dat_rd_cnt, isa_rd_data, dat_rd_data,
         rd_burst_addr, rd_burst_len, isa_rd_data_valid, dat_rd_data_valid} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got g%b%b req%b cnt %0d valid %b addr %h want all 0",
                         isa_rd_grant, dat_rd_grant, rd_burst_req, isa_rd_cnt, isa_rd_data_valid, rd_burst_addr);
    end
    exp_isa_data = '0; exp_dat_data = '0;
`ifdef RR_ARB_EN
    model_last_isa = 1'b0;
`endif
    isa_rd_req = 0; rd_burst_data_valid = 0;
    tick();
    rst = 1'b1;
    tick();
    model_pick(1, 0, w);
    isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = LW'(3);
    wait_grant(cyc);
    n_checks++;
    if (isa_rd_grant !== 1'b1 || isa_rd_cnt !== '0 || rd_burst_req !== 1'b1 || rd_burst_addr !== isa_rd_addr) begin
      n_fail++; $display("FAIL reset_restart: got g%b cnt %0d req%b want 1 0 1", isa_rd_grant, isa_rd_cnt, rd_burst_req);
    end
    send_beats(3, 1, last);
    exp_isa_data = last[IW-1:0];
    n_checks++;
    if (isa_rd_cnt !== LW'(3) || isa_rd_data !== exp_isa_data) begin
      n_fail++; $display("FAIL reset_restart_cnt: got cnt %0d data %h want 3 %h", isa_rd_cnt, isa_rd_data, exp_isa_data);
    end
    finish_burst();
    isa_rd_req = 0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] last;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    int cyc, s0, d0;
    bit ri = 0, rd = 0, wi;
    for (int it = 0; it < 12; it++) begin
      if (!ri && $urandom_range(0, 1) == 1) begin
        ri = 1; isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = LW'($urandom_range(0, 12));
      end
      if (!rd && $urandom_range(0, 1) == 1) begin
        rd = 1; dat_rd_req = 1; dat_rd_addr = AW'($urandom()); dat_rd_len = LW'($urandom_range(0, 12));
      end
      if (!ri && !rd) begin
        ri = 1; isa_rd_req = 1; isa_rd_addr = AW'($urandom()); isa_rd_len = LW'($urandom_range(0, 12));
      end
      model_pick(ri, rd, wi);
      e_addr = wi ? isa_rd_addr : dat_rd_addr;
      e_len  = wi ? isa_rd_len : dat_rd_len;
      wait_grant(cyc);
      n_checks++;
      if (cyc >= 20 || {isa_rd_grant, dat_rd_grant} !== {wi, !wi} || rd_burst_addr !== e_addr ||
          rd_burst_len !== e_len || rd_burst_req !== (e_len != 0)) begin
        n_fail++; $display("FAIL rand_grant[%0d]: got g%b%b addr %h len %0d req%b want g%b%b addr %h len %0d",
                           it, isa_rd_grant, dat_rd_grant, rd_burst_addr, rd_burst_len, rd_burst_req,
                           wi, !wi, e_addr, e_len);
      end
      if (wi) isa_rd_addr = AW'($urandom()); else dat_rd_addr = AW'($urandom());
      s0 = isa_strobes; d0 = dat_strobes;
      if (e_len != 0) begin
        send_beats(int'(e_len), 1, last);
        if (wi) exp_isa_data = last[IW-1:0]; else exp_dat_data = last[TW-1:0];
        finish_burst();
      end
      n_checks++;
      if ((wi ? isa_rd_cnt : dat_rd_cnt) !== e_len || (wi ? dat_rd_cnt : isa_rd_cnt) !== '0 ||
          isa_rd_data !== exp_isa_data || dat_rd_data !== exp_dat_data ||
          (wi ? isa_strobes - s0 : dat_strobes - d0) != int'(e_len) ||
          (wi ? dat_strobes - d0 : isa_strobes - s0) != 0) begin
        n_fail++; $display("FAIL rand_beats[%0d]: got cnt %0d/%0d data %h/%h want len %0d data %h/%h",
                           it, isa_rd_cnt, dat_rd_cnt, isa_rd_data, dat_rd_data, e_len, exp_isa_data, exp_dat_data);
      end
      if (wi) begin isa_rd_req = 0; ri = 0; end
      else begin dat_rd_req = 0; rd = 0; end
      tick();
      n_checks++;
      if ({isa_rd_grant, dat_rd_grant} !== 2'b00) begin
        n_fail++; $display("FAIL rand_release[%0d]: got g%b%b want 00", it, isa_rd_grant, dat_rd_grant);
      end
    end
    isa_rd_req = 0; dat_rd_req = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_isa_burst();
    test_simultaneous();
    test_drop_mid_burst();
    test_len_zero();
    test_idle_pulses();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
